// File: rtl/rgb_frame_fetch.sv
// Fetches one packed 8-bit RGB frame from SRAM and streams pixels over a valid/ready port.
// Define RGB_FRAME_FETCH_CHECKSUM_EN to add a 16-bit running sum of fetched words.
module rgb_frame_fetch #(
  parameter int unsigned H_PIXELS     = 320,
  parameter int unsigned V_LINES      = 240,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic        Clock_50,
  input  logic        Resetn,
  input  logic        Start,
  input  logic [17:0] Base_address,
  output logic [17:0] SRAM_address,
  output logic        SRAM_we_n,
  input  logic [15:0] SRAM_read_data,
  output logic        Busy,
  output logic        Pixel_valid,
  input  logic        Pixel_ready,
  output logic [7:0]  Pixel_R,
  output logic [7:0]  Pixel_G,
  output logic [7:0]  Pixel_B,
`ifdef RGB_FRAME_FETCH_CHECKSUM_EN
  output logic [15:0] Checksum,
`endif
  output logic        Frame_done
);

  localparam int unsigned TotalPixels = H_PIXELS * V_LINES;
  localparam int unsigned TotalWords  = (3 * TotalPixels) / 2;
  localparam int unsigned WcW         = $clog2(TotalWords + 1);
  localparam int unsigned PcW         = $clog2(TotalPixels + 1);
  localparam int unsigned PtrW        = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW        = PtrW + 1;

  localparam logic [WcW-1:0] LastWord  = WcW'(TotalWords - 1);
  localparam logic [PcW-1:0] LastPixel = PcW'(TotalPixels - 1);
  localparam logic [CntW:0]  Credits   = (CntW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

  state_e                state_q;
  logic [17:0]           base_q;
  logic [WcW-1:0]        word_cnt_q;
  logic [PcW-1:0]        pix_cnt_q;
  logic [READ_LATENCY:0] rd_tag_q;
  logic [CntW-1:0]       inflight_q;
  logic [CntW-1:0]       fifo_cnt_q;
  logic [PtrW-1:0]       wr_ptr_q;
  logic [PtrW-1:0]       rd_ptr_q;
  logic [15:0]           fifo_mem [FIFO_DEPTH];
  logic                  odd_q;

  logic        active;
  logic        issue;
  logic        push;
  logic        xfer;
  logic        load;
  logic [1:0]  pop_n;
  logic [15:0] head_w;
  logic [15:0] next_w;

  assign SRAM_we_n = 1'b1;

  always_comb begin
    active = (state_q == StFetch) || (state_q == StDrain);
    // Credit check: everything already owed to the FIFO must still fit after this read.
    issue  = (state_q == StFetch) && (({1'b0, fifo_cnt_q} + {1'b0, inflight_q}) < Credits);
    push   = rd_tag_q[READ_LATENCY];
    xfer   = Pixel_valid && Pixel_ready;
    head_w = fifo_mem[rd_ptr_q];
    next_w = fifo_mem[rd_ptr_q + PtrW'(1)];
    // Both pixel shapes need two words at the head: {W0,W1} or {W1,W2}.
    load   = active && (fifo_cnt_q >= CntW'(2)) && (!Pixel_valid || Pixel_ready);
    pop_n  = 2'd0;
    if (load) begin
      pop_n = odd_q ? 2'd2 : 2'd1;
    end
  end

  always_ff @(posedge Clock_50) begin
    if (Resetn && push) begin
      fifo_mem[wr_ptr_q] <= SRAM_read_data;
    end
  end

  always_ff @(posedge Clock_50) begin
    if (!Resetn) begin
      state_q      <= StIdle;
      base_q       <= '0;
      word_cnt_q   <= '0;
      pix_cnt_q    <= '0;
      rd_tag_q     <= '0;
      inflight_q   <= '0;
      fifo_cnt_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      odd_q        <= 1'b0;
      SRAM_address <= '0;
      Busy         <= 1'b0;
      Pixel_valid  <= 1'b0;
      Pixel_R      <= '0;
      Pixel_G      <= '0;
      Pixel_B      <= '0;
      Frame_done   <= 1'b0;
    end else begin
      rd_tag_q   <= {rd_tag_q[READ_LATENCY-1:0], issue};
      inflight_q <= inflight_q + CntW'(issue) - CntW'(push);
      fifo_cnt_q <= fifo_cnt_q + CntW'(push) - CntW'(pop_n);
      rd_ptr_q   <= rd_ptr_q + PtrW'(pop_n);
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (xfer) begin
        pix_cnt_q <= pix_cnt_q + PcW'(1);
      end

      if (load) begin
        Pixel_valid <= 1'b1;
        odd_q       <= !odd_q;
        if (!odd_q) begin
          Pixel_R <= head_w[15:8];
          Pixel_G <= head_w[7:0];
          Pixel_B <= next_w[15:8];
        end else begin
          Pixel_R <= head_w[7:0];
          Pixel_G <= next_w[15:8];
          Pixel_B <= next_w[7:0];
        end
      end else if (xfer) begin
        Pixel_valid <= 1'b0;
      end

      Frame_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (Start) begin
            base_q     <= Base_address;
            word_cnt_q <= '0;
            pix_cnt_q  <= '0;
            odd_q      <= 1'b0;
            Busy       <= 1'b1;
            state_q    <= StFetch;
          end
        end
        StFetch: begin
          if (issue) begin
            SRAM_address <= base_q + 18'(word_cnt_q);
            word_cnt_q   <= word_cnt_q + WcW'(1);
            if (word_cnt_q == LastWord) begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          if (xfer && (pix_cnt_q == LastPixel)) begin
            Busy       <= 1'b0;
            Frame_done <= 1'b1;
            state_q    <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

`ifdef RGB_FRAME_FETCH_CHECKSUM_EN
  logic [15:0] checksum_q;

  always_ff @(posedge Clock_50) begin
    if (!Resetn) begin
      checksum_q <= '0;
    end else if ((state_q == StIdle) && Start) begin
      checksum_q <= '0;
    end else if (push) begin
      checksum_q <= checksum_q + SRAM_read_data;
    end
  end

  assign Checksum = checksum_q;
`endif

endmodule

// File: tb/tb_rgb_frame_fetch.sv
// Scoreboard bench for rgb_frame_fetch on a reduced 40x20 frame with a latency-2 SRAM model.
module tb_rgb_frame_fetch;

  localparam int unsigned HP     = 40;
  localparam int unsigned VL     = 20;
  localparam int unsigned FD     = 8;
  localparam int unsigned RL     = 2;
  localparam int unsigned NPIX   = HP * VL;
  localparam int unsigned NWORDS = (3 * NPIX) / 2;

  logic        Clock_50     = 1'b0;
  logic        Resetn       = 1'b0;
  logic        Start        = 1'b0;
  logic [17:0] Base_address = '0;
  logic        Pixel_ready  = 1'b0;
  logic [17:0] SRAM_address;
  logic        SRAM_we_n;
  logic [15:0] SRAM_read_data;
  logic        Busy;
  logic        Pixel_valid;
  logic [7:0]  Pixel_R;
  logic [7:0]  Pixel_G;
  logic [7:0]  Pixel_B;
  logic        Frame_done;
`ifdef RGB_FRAME_FETCH_CHECKSUM_EN
  logic [15:0] Checksum;
`endif

  always #10 Clock_50 = ~Clock_50;

  rgb_frame_fetch #(
    .H_PIXELS    (HP),
    .V_LINES     (VL),
    .FIFO_DEPTH  (FD),
    .READ_LATENCY(RL)
  ) dut (
    .Clock_50      (Clock_50),
    .Resetn        (Resetn),
    .Start         (Start),
    .Base_address  (Base_address),
    .SRAM_address  (SRAM_address),
    .SRAM_we_n     (SRAM_we_n),
    .SRAM_read_data(SRAM_read_data),
    .Busy          (Busy),
    .Pixel_valid   (Pixel_valid),
    .Pixel_ready   (Pixel_ready),
    .Pixel_R       (Pixel_R),
    .Pixel_G       (Pixel_G),
    .Pixel_B       (Pixel_B),
`ifdef RGB_FRAME_FETCH_CHECKSUM_EN
    .Checksum      (Checksum),
`endif
    .Frame_done    (Frame_done)
  );

  // SRAM model: explicit overrides, an all-0x0001 fill mode, else an address hash.
  logic [15:0] ovr [logic [17:0]];
  bit          fill_ones = 1'b0;
  logic [17:0] a1;

  function automatic logic [15:0] mem_word(input logic [17:0] a);
    if (ovr.exists(a)) return ovr[a];
    if (fill_ones) return 16'h0001;
    return (a[15:0] * 16'd40503) ^ {14'd0, a[17:16]};
  endfunction

  always @(posedge Clock_50) begin
    a1             <= SRAM_address;
    SRAM_read_data <= mem_word(a1);
  end

  logic [23:0] exp_q [$];
  int          tmo_cnt = 0;

  // Monitor-owned state and counters.
  int          vectors     = 0;
  int          miscompares = 0;
  int          frames      = 0;
  int          tmo_seen    = 0;
  int          issued      = 0;
  int          xfer_cnt    = 0;
  int          lat_cnt     = 0;
  bit          first_seen  = 1'b0;
  bit          rst_prev    = 1'b0;
  bit          stall_prev  = 1'b0;
  bit          done_prev   = 1'b0;
  logic [23:0] stall_rgb;
  logic [17:0] exp_addr    = '0;
  logic [17:0] prev_addr   = '0;
  logic [15:0] exp_sum     = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge Clock_50) begin
    int formed;
    int removed;
    logic [23:0] e;
    if (!Resetn) begin
      exp_q.delete();
      stall_prev = 1'b0;
      done_prev  = 1'b0;
      if (rst_prev) begin
        chk("reset_addr", 32'(SRAM_address), 32'h0);
        chk("reset_we_n", 32'(SRAM_we_n), 32'h1);
        chk("reset_busy", 32'(Busy), 32'h0);
        chk("reset_valid", 32'(Pixel_valid), 32'h0);
        chk("reset_rgb", 32'({Pixel_R, Pixel_G, Pixel_B}), 32'h0);
        chk("reset_done", 32'(Frame_done), 32'h0);
      end
      rst_prev = 1'b1;
    end else begin
      rst_prev = 1'b0;
      if (tmo_cnt != tmo_seen) begin
        vectors++;
        miscompares++;
        $display("FAIL wait_timeout: got %0d timeouts, expected %0d", tmo_cnt, tmo_seen);
        tmo_seen = tmo_cnt;
      end
      if (Start && !Busy && !Frame_done) begin
        exp_addr   = Base_address;
        prev_addr  = SRAM_address;
        issued     = 0;
        xfer_cnt   = 0;
        lat_cnt    = 0;
        first_seen = 1'b0;
        exp_sum    = '0;
        for (int k = 0; k < NWORDS; k++) exp_sum = exp_sum + mem_word(Base_address + 18'(k));
      end else begin
        lat_cnt++;
      end
      if (Busy) begin
        if (SRAM_address == exp_addr) begin
          issued++;
          exp_addr = exp_addr + 18'd1;
        end else if (issued == 0) begin
          chk("first_addr", 32'(SRAM_address), 32'(prev_addr));
        end else begin
          chk("addr_seq", 32'(SRAM_address), 32'(exp_addr - 18'd1));
        end
        formed  = xfer_cnt + (Pixel_valid ? 1 : 0);
        removed = 3 * (formed / 2) + (formed % 2);
        vectors++;
        if (issued - removed > int'(FD)) begin
          miscompares++;
          $display("FAIL credit_bound: got %0d words owed, expected <= %0d", issued - removed, FD);
        end
      end
      if (Pixel_valid && !first_seen) begin
        first_seen = 1'b1;
        vectors++;
        if (lat_cnt < int'(RL) + 2) begin
          miscompares++;
          $display("FAIL first_pixel_latency: got %0d, expected >= %0d", lat_cnt, RL + 2);
        end
      end
      if (stall_prev) begin
        chk("stall_valid", 32'(Pixel_valid), 32'h1);
        chk("stall_rgb", 32'({Pixel_R, Pixel_G, Pixel_B}), 32'(stall_rgb));
      end
      if (Pixel_valid && Pixel_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_pixel: got %h, expected none", {Pixel_R, Pixel_G, Pixel_B});
        end else begin
          e = exp_q.pop_front();
          chk("pixel", 32'({Pixel_R, Pixel_G, Pixel_B}), 32'(e));
        end
        xfer_cnt++;
      end
      stall_prev = Pixel_valid && !Pixel_ready;
      stall_rgb  = {Pixel_R, Pixel_G, Pixel_B};
      if (done_prev) begin
        chk("done_single_pulse", 32'(Frame_done), 32'h0);
        chk("busy_after_done", 32'(Busy), 32'h0);
      end
      if (Frame_done) begin
        frames++;
        chk("done_busy", 32'(Busy), 32'h0);
        chk("transfers", 32'(xfer_cnt), 32'(NPIX));
        chk("reads", 32'(issued), 32'(NWORDS));
        chk("queue_left", 32'(exp_q.size()), 32'h0);
`ifdef RGB_FRAME_FETCH_CHECKSUM_EN
        chk("checksum", 32'(Checksum), 32'(exp_sum));
        if (fill_ones) chk("checksum_ones", 32'(Checksum), 32'h04B0);
`endif
      end
      done_prev = Frame_done;
    end
  end

  task automatic step();
    @(posedge Clock_50);
    #1;
  endtask

  task automatic push_frame(input logic [17:0] base, input bit hand);
    logic [17:0] a;
    logic [15:0] w0;
    logic [15:0] w1;
    logic [15:0] w2;
    for (int k = 0; k < int'(NPIX / 2); k++) begin
      a  = base + 18'(3 * k);
      w0 = mem_word(a);
      w1 = mem_word(a + 18'd1);
      w2 = mem_word(a + 18'd2);
      if (hand && k == 0) begin
        exp_q.push_back(24'h112233);
        exp_q.push_back(24'h445566);
      end else begin
        exp_q.push_back({w0, w1[15:8]});
        exp_q.push_back({w1[7:0], w2});
      end
    end
  endtask

  task automatic start_frame(input logic [17:0] base, input bit hand);
    push_frame(base, hand);
    Base_address = base;
    Start        = 1'b1;
    step();
    Start        = 1'b0;
  endtask

  // mode 0: always ready; 1: 30% random ready; 2: ready low for 60 cycles, then high.
  task automatic run_frame(input int mode, input bit poke);
    int f0;
    int n;
    f0 = frames;
    n  = 0;
    while (frames == f0 && n < 20000) begin
      case (mode)
        1:       Pixel_ready = ($urandom_range(0, 9) < 3);
        2:       Pixel_ready = (n >= 60);
        default: Pixel_ready = 1'b1;
      endcase
      if (poke && n == 100) begin
        Start        = 1'b1;
        Base_address = 18'h2AAAA;
      end else begin
        Start = 1'b0;
      end
      step();
      n++;
    end
    if (frames == f0) tmo_cnt++;
    Start       = 1'b0;
    Pixel_ready = 1'b1;
  endtask

  initial begin
    int n;
    Resetn = 1'b0;
    repeat (3) step();
    Resetn = 1'b1;
    step();

    ovr[18'h00100] = 16'h1122;
    ovr[18'h00101] = 16'h3344;
    ovr[18'h00102] = 16'h5566;
    Pixel_ready = 1'b1;
    start_frame(18'h00100, 1'b1);
    run_frame(0, 1'b1);

    start_frame(18'h3FF00, 1'b0);
    run_frame(1, 1'b0);

    start_frame(18'h01000, 1'b0);
    n = 0;
    while (SRAM_address != 18'h011F4 && n < 5000) begin
      step();
      n++;
    end
    if (n >= 5000) tmo_cnt++;
    Resetn = 1'b0;
    repeat (3) step();
    Resetn = 1'b1;
    step();
    start_frame(18'h23E00, 1'b0);
    run_frame(2, 1'b0);

    fill_ones = 1'b1;
    start_frame(18'h00200, 1'b0);
    run_frame(0, 1'b0);

    repeat (5) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
